// File: rtl/quickq_bram_sequencer.sv
// Sorted-store sequencer over a single-port BRAM. Enqueue and dequeue each take 2n+1 busy cycles (n = count),
// then a one-cycle RSP. cmd_ready is high only in IDLE and RSP; commands arriving while busy wait on cmd_valid.
module quickq_bram_sequencer #(
  parameter int KW    = 16,
  parameter int DEPTH = 16,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          cmd_valid,
  output logic          cmd_ready,
  input  logic          cmd_op,
  input  logic [KW-1:0] cmd_key,
  output logic          rsp_valid,
  output logic          rsp_err,
  output logic [KW-1:0] rsp_key,
  output logic [AW:0]   count,
  output logic          empty,
  output logic          full,
  output logic [AW-1:0] ram_addr,
  output logic          ram_we,
  output logic [KW-1:0] ram_wdata,
  input  logic [KW-1:0] ram_rdata
);

  typedef enum logic [3:0] {
    S_IDLE, S_E_RD, S_E_CMP, S_E_APP,
    S_D_HRD, S_D_HCAP, S_D_RD, S_D_WR, S_D_FIN, S_RSP
  } state_t;

  localparam logic [AW:0] LP_DEPTH = DEPTH[AW:0];
  localparam logic [AW:0] LP_ONE   = {{AW{1'b0}}, 1'b1};
  localparam logic [AW:0] LP_TWO   = LP_ONE + LP_ONE;

  state_t        r_state;
  logic [AW:0]   r_i;
  logic [KW-1:0] r_carry;
  logic [AW:0]   r_count;
  logic          r_err;
  logic [KW-1:0] r_rsp_key;

  logic          w_ready;
  logic          w_empty;
  logic          w_full;
  logic          w_swap;
  logic [AW:0]   w_i_inc;
  logic [AW:0]   w_i_inc2;

  assign w_ready  = (r_state == S_IDLE) || (r_state == S_RSP);
  assign w_empty  = (r_count == '0);
  assign w_full   = (r_count == LP_DEPTH);
  // Strict compare: equal keys never swap, so later arrivals stay behind earlier ones.
  assign w_swap   = (r_carry < ram_rdata);
  assign w_i_inc  = r_i + LP_ONE;
  assign w_i_inc2 = r_i + LP_TWO;

  assign cmd_ready = w_ready;
  assign rsp_valid = (r_state == S_RSP);
  assign rsp_err   = (r_state == S_RSP) && r_err;
  assign rsp_key   = r_rsp_key;
  assign count     = r_count;
  assign empty     = w_empty;
  assign full      = w_full;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= S_IDLE;
      r_i       <= '0;
      r_carry   <= '0;
      r_count   <= '0;
      r_err     <= 1'b0;
      r_rsp_key <= '0;
    end else begin
      case (r_state)
        S_IDLE, S_RSP: begin
          r_state <= S_IDLE;
          if (cmd_valid) begin
            r_i     <= '0;
            r_carry <= cmd_key;
            r_err   <= 1'b0;
            if (!cmd_op) begin
              if (w_full) begin
                r_err   <= 1'b1;
                r_state <= S_RSP;
              end else if (w_empty) begin
                r_state <= S_E_APP;
              end else begin
                r_state <= S_E_RD;
              end
            end else begin
              if (w_empty) begin
                r_err   <= 1'b1;
                r_state <= S_RSP;
              end else begin
                r_state <= S_D_HRD;
              end
            end
          end
        end
        S_E_RD: r_state <= S_E_CMP;
        S_E_CMP: begin
          if (w_swap) r_carry <= ram_rdata;
          r_i     <= w_i_inc;
          r_state <= (w_i_inc == r_count) ? S_E_APP : S_E_RD;
        end
        S_E_APP: begin
          r_count <= r_count + LP_ONE;
          r_state <= S_RSP;
        end
        S_D_HRD: r_state <= S_D_HCAP;
        S_D_HCAP: begin
          r_rsp_key <= ram_rdata;
          r_i       <= '0;
          r_state   <= (r_count == LP_ONE) ? S_D_FIN : S_D_RD;
        end
        S_D_RD: r_state <= S_D_WR;
        S_D_WR: begin
          r_i     <= w_i_inc;
          r_state <= (w_i_inc2 == r_count) ? S_D_FIN : S_D_RD;
        end
        S_D_FIN: begin
          r_count <= r_count - LP_ONE;
          r_state <= S_RSP;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Address depends only on registered state; only write enable/data look at ram_rdata.
  always_comb begin
    ram_addr  = '0;
    ram_we    = 1'b0;
    ram_wdata = '0;
    case (r_state)
      S_E_RD: ram_addr = r_i[AW-1:0];
      S_E_CMP: begin
        ram_addr  = r_i[AW-1:0];
        ram_we    = w_swap;
        ram_wdata = w_swap ? r_carry : '0;
      end
      S_E_APP: begin
        ram_addr  = r_count[AW-1:0];
        ram_we    = 1'b1;
        ram_wdata = r_carry;
      end
      S_D_RD: ram_addr = w_i_inc[AW-1:0];
      S_D_WR: begin
        ram_addr  = r_i[AW-1:0];
        ram_we    = 1'b1;
        ram_wdata = ram_rdata;
      end
      default: begin
        ram_addr  = '0;
        ram_we    = 1'b0;
        ram_wdata = '0;
      end
    endcase
  end

endmodule
